// File: rtl/pattern_scheduler.sv
// Timed stimulus scheduler: applies each {bin, dec, hex} entry onto registered outputs in the
// exact cycle the internal timebase equals the entry's timestamp; late entries are dropped and flagged.
module pattern_scheduler #(
  parameter int TS_W  = 32,
  parameter int BIN_W = 4,
  parameter int DEC_W = 32,
  parameter int HEX_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_comment,
  input  logic             in_last,
  input  logic [TS_W-1:0]  in_ts,
  input  logic [BIN_W-1:0] in_bin,
  input  logic [DEC_W-1:0] in_dec,
  input  logic [HEX_W-1:0] in_hex,
  output logic [BIN_W-1:0] out_bin,
  output logic [DEC_W-1:0] out_dec,
  output logic [HEX_W-1:0] out_hex,
  output logic             out_strobe,
  output logic [TS_W-1:0]  now,
  output logic             busy,
  output logic             done,
  output logic             err_order,
  output logic [TS_W-1:0]  err_ts,
  output logic [CNT_W-1:0] err_count,
  output logic             err_ovf
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  localparam logic [TS_W-1:0]  TS_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [TS_W-1:0]    pend_ts;
  logic [BIN_W-1:0]   pend_bin;
  logic [DEC_W-1:0]   pend_dec;
  logic [HEX_W-1:0]   pend_hex;
  logic               pend_last;

  logic               now_sat;
  logic [TS_W-1:0]    next_now;
  logic               handshake;
  logic               late;

  // Everything is keyed to the value now will take after this edge, so the
  // strobe and out_* land registered in the very cycle now equals the timestamp.
  always_comb begin
    now_sat   = (now == TS_MAX);
    next_now  = (hold || now_sat) ? now : now + TS_W'(1);
    handshake = in_valid && (state == FETCH);
    late      = (in_ts <= now);
  end

  assign in_ready = (state == FETCH);
  assign busy     = (state == FETCH) || (state == WAIT);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      now        <= '0;
      out_bin    <= '0;
      out_dec    <= '0;
      out_hex    <= '0;
      out_strobe <= 1'b0;
      err_order  <= 1'b0;
      err_ts     <= '0;
      err_count  <= '0;
      err_ovf    <= 1'b0;
      pend_ts    <= '0;
      pend_bin   <= '0;
      pend_dec   <= '0;
      pend_hex   <= '0;
      pend_last  <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= FETCH;
              now       <= '0;
              err_order <= 1'b0;
              err_ts    <= '0;
              err_count <= '0;
              err_ovf   <= 1'b0;
            end
          end
          FETCH: begin
            now <= next_now;
            if (handshake) begin
              if (in_comment) begin
                if (in_last) state <= DONE;
              end else if (late) begin
                err_order <= 1'b1;
                err_ts    <= in_ts;
                if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                if (in_last) state <= DONE;
              end else begin
                pend_ts   <= in_ts;
                pend_bin  <= in_bin;
                pend_dec  <= in_dec;
                pend_hex  <= in_hex;
                pend_last <= in_last;
                state     <= WAIT;
                // An entry due right at now+1 must be applied straight away.
                if (in_ts == next_now) begin
                  out_bin    <= in_bin;
                  out_dec    <= in_dec;
                  out_hex    <= in_hex;
                  out_strobe <= 1'b1;
                end
              end
            end
          end
          WAIT: begin
            now <= next_now;
            if (out_strobe) begin
              state <= pend_last ? DONE : FETCH;
            end else if (next_now == pend_ts) begin
              out_bin    <= pend_bin;
              out_dec    <= pend_dec;
              out_hex    <= pend_hex;
              out_strobe <= 1'b1;
            end else if (now_sat) begin
              err_ovf <= 1'b1;
              state   <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler: a 32-bit timebase instance for the main scenarios and
// a 4-bit timebase / 2-bit counter instance for the saturation edges; strobes checked against a queue.
module tb_pattern_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, start4, abort, hold;
  logic        in_valid, in_comment, in_last;
  logic [31:0] in_ts, in_dec, in_hex;
  logic [3:0]  in_bin;

  logic        in_ready, out_strobe, busy, done, err_order, err_ovf;
  logic [3:0]  out_bin;
  logic [31:0] out_dec, out_hex, now, err_ts;
  logic [7:0]  err_count;

  logic        in_ready4, out_strobe4, busy4, done4, err_order4, err_ovf4;
  logic [3:0]  out_bin4, now4, err_ts4;
  logic [31:0] out_dec4, out_hex4;
  logic [1:0]  err_count4;

  typedef struct {
    logic [31:0] ts;
    logic [3:0]  bin;
    logic [31:0] dec;
    logic [31:0] hex;
  } exp_t;

  exp_t        q[$];
  exp_t        q4[$];
  exp_t        em, em4;
  logic [3:0]  m_bin;
  logic [31:0] m_dec, m_hex;
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          c_first = 0;
  int          strobe_cyc = 0;

  pattern_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_comment(in_comment), .in_last(in_last),
    .in_ts(in_ts), .in_bin(in_bin), .in_dec(in_dec), .in_hex(in_hex),
    .out_bin(out_bin), .out_dec(out_dec), .out_hex(out_hex), .out_strobe(out_strobe),
    .now(now), .busy(busy), .done(done), .err_order(err_order), .err_ts(err_ts),
    .err_count(err_count), .err_ovf(err_ovf)
  );

  pattern_scheduler #(.TS_W(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready4), .in_comment(in_comment), .in_last(in_last),
    .in_ts(in_ts[3:0]), .in_bin(in_bin), .in_dec(in_dec), .in_hex(in_hex),
    .out_bin(out_bin4), .out_dec(out_dec4), .out_hex(out_hex4), .out_strobe(out_strobe4),
    .now(now4), .busy(busy4), .done(done4), .err_order(err_order4), .err_ts(err_ts4),
    .err_count(err_count4), .err_ovf(err_ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every strobe must match the oldest outstanding expected entry, including the now it lands on.
  always @(negedge clk) begin
    if (!rst && out_strobe) begin
      if (q.size() == 0) begin
        checkOutput("unexpected_strobe", 64'(out_strobe), 64'(0));
      end else begin
        em = q.pop_front();
        checkOutput("strobe_now", 64'(now), 64'(em.ts));
        checkOutput("strobe_bin", 64'(out_bin), 64'(em.bin));
        checkOutput("strobe_dec", 64'(out_dec), 64'(em.dec));
        checkOutput("strobe_hex", 64'(out_hex), 64'(em.hex));
        m_bin = em.bin;
        m_dec = em.dec;
        m_hex = em.hex;
        strobe_cyc = cyc;
      end
    end
    if (!rst && out_strobe4) begin
      if (q4.size() == 0) begin
        checkOutput("unexpected_strobe4", 64'(out_strobe4), 64'(0));
      end else begin
        em4 = q4.pop_front();
        checkOutput("strobe4_now", 64'(now4), 64'(em4.ts));
        checkOutput("strobe4_bin", 64'(out_bin4), 64'(em4.bin));
        checkOutput("strobe4_hex", 64'(out_hex4), 64'(em4.hex));
      end
    end
  end

  task automatic startRun(input bit sel4);
    if (sel4) start4 = 1'b1; else start = 1'b1;
    tick();
    start  = 1'b0;
    start4 = 1'b0;
    c_first = cyc;
    checkOutput("start_now0", sel4 ? 64'(now4) : 64'(now), 64'(0));
    checkOutput("start_ready", sel4 ? 64'(in_ready4) : 64'(in_ready), 64'(1));
  endtask

  task automatic applyStimulus(input bit sel4, input logic [31:0] ts, input logic [3:0] bin,
                               input logic [31:0] dec, input logic [31:0] hex,
                               input bit comment, input bit last, input bit exp_apply,
                               input string tag);
    exp_t e;
    bit   rdy;
    if (exp_apply) begin
      e.ts = ts; e.bin = bin; e.dec = dec; e.hex = hex;
      if (sel4) q4.push_back(e); else q.push_back(e);
    end
    in_valid = 1'b1; in_comment = comment; in_last = last;
    in_ts = ts; in_bin = bin; in_dec = dec; in_hex = hex;
    rdy = 1'b0;
    for (int i = 0; i < 300 && !rdy; i++) begin
      rdy = sel4 ? in_ready4 : in_ready;
      tick();
    end
    in_valid = 1'b0; in_comment = 1'b0; in_last = 1'b0;
    checkOutput({tag, "_accept"}, 64'(rdy), 64'(1));
  endtask

  task automatic waitStrobe(input bit sel4, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (sel4 ? out_strobe4 : out_strobe) seen = 1'b1;
      else tick();
    end
    checkOutput(tag, 64'(seen), 64'(1));
  endtask

  task automatic waitDone(input bit sel4, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (sel4 ? done4 : done) seen = 1'b1;
      else tick();
    end
    checkOutput(tag, 64'(seen), 64'(1));
  endtask

  task automatic waitNow(input logic [31:0] value, input string tag);
    for (int i = 0; i < 300 && now != value; i++) tick();
    checkOutput(tag, 64'(now), 64'(value));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0; hold = 1'b0;
    in_valid = 1'b0; in_comment = 1'b0; in_last = 1'b0;
    in_ts = '0; in_bin = '0; in_dec = '0; in_hex = '0;
    m_bin = '0; m_dec = '0; m_hex = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 64'(in_ready), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_now", 64'(now), 64'(0));
    checkOutput("rst_out_dec", 64'(out_dec), 64'(0));
    checkOutput("rst_err_count", 64'(err_count), 64'(0));
    checkOutput("rst4_busy", 64'(busy4), 64'(0));
    rst = 1'b0;
    tick();

    $display("[TB] scenario 1: two entries, in order");
    startRun(1'b0);
    applyStimulus(1'b0, 32'd5, 4'b1010, 32'd17, 32'hDEAD, 1'b0, 1'b0, 1'b1, "t1_e0");
    applyStimulus(1'b0, 32'd9, 4'b0001, 32'd3, 32'hBEEF, 1'b0, 1'b1, 1'b1, "t1_e1");
    waitStrobe(1'b0, "t1_strobe_seen");
    tick();
    checkOutput("t1_done", 64'(done), 64'(1));
    checkOutput("t1_busy", 64'(busy), 64'(0));
    checkOutput("t1_err_count", 64'(err_count), 64'(0));

    $display("[TB] scenario 2: late entry dropped");
    startRun(1'b0);
    applyStimulus(1'b0, 32'd8, 4'h3, 32'd8, 32'h0808, 1'b0, 1'b0, 1'b1, "t2_e0");
    applyStimulus(1'b0, 32'd4, 4'h4, 32'd4, 32'h0404, 1'b0, 1'b0, 1'b0, "t2_late");
    applyStimulus(1'b0, 32'd12, 4'h7, 32'd12, 32'h1212, 1'b0, 1'b1, 1'b1, "t2_e1");
    waitDone(1'b0, "t2_done");
    checkOutput("t2_err_order", 64'(err_order), 64'(1));
    checkOutput("t2_err_ts", 64'(err_ts), 64'(4));
    checkOutput("t2_err_count", 64'(err_count), 64'(1));
    checkOutput("t2_err_ovf", 64'(err_ovf), 64'(0));

    $display("[TB] scenario 3: comment and valid gaps");
    startRun(1'b0);
    applyStimulus(1'b0, 32'd3, 4'h5, 32'd33, 32'h0333, 1'b0, 1'b0, 1'b1, "t3_e0");
    tick();
    tick();
    applyStimulus(1'b0, 32'd1, 4'hE, 32'd99, 32'h0999, 1'b1, 1'b0, 1'b0, "t3_comment");
    applyStimulus(1'b0, 32'd6, 4'h6, 32'd66, 32'h0666, 1'b0, 1'b1, 1'b1, "t3_e1");
    waitDone(1'b0, "t3_done");
    checkOutput("t3_err_order", 64'(err_order), 64'(0));
    checkOutput("t3_err_count", 64'(err_count), 64'(0));

    $display("[TB] scenario 4: hold delays the apply");
    startRun(1'b0);
    applyStimulus(1'b0, 32'd10, 4'hC, 32'd1010, 32'hA0A0, 1'b0, 1'b1, 1'b1, "t4_e0");
    waitNow(32'd6, "t4_reach6");
    hold = 1'b1;
    repeat (4) tick();
    hold = 1'b0;
    checkOutput("t4_hold_now", 64'(now), 64'(6));
    waitNow(32'd9, "t4_reach9");
    checkOutput("t4_pre_bin", 64'(out_bin), 64'(m_bin));
    checkOutput("t4_pre_hex", 64'(out_hex), 64'(m_hex));
    checkOutput("t4_pre_strobe", 64'(out_strobe), 64'(0));
    waitDone(1'b0, "t4_done");
    checkOutput("t4_delay", 64'(strobe_cyc - c_first), 64'(14));

    $display("[TB] scenario 5: abort then restart");
    startRun(1'b0);
    applyStimulus(1'b0, 32'd2, 4'h9, 32'd22, 32'h2222, 1'b0, 1'b0, 1'b1, "t5_e0");
    applyStimulus(1'b0, 32'd1, 4'h1, 32'd11, 32'h1111, 1'b0, 1'b0, 1'b0, "t5_late");
    applyStimulus(1'b0, 32'd20, 4'h2, 32'd20, 32'h2020, 1'b0, 1'b1, 1'b0, "t5_e1");
    waitNow(32'd15, "t5_reach15");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5_abort_busy", 64'(busy), 64'(0));
    checkOutput("t5_abort_done", 64'(done), 64'(0));
    checkOutput("t5_abort_strobe", 64'(out_strobe), 64'(0));
    checkOutput("t5_abort_bin", 64'(out_bin), 64'(m_bin));
    checkOutput("t5_abort_dec", 64'(out_dec), 64'(m_dec));
    checkOutput("t5_abort_err_ts", 64'(err_ts), 64'(1));
    checkOutput("t5_abort_err_count", 64'(err_count), 64'(1));
    repeat (8) tick();
    checkOutput("t5_idle_busy", 64'(busy), 64'(0));
    startRun(1'b0);
    checkOutput("t5_restart_err_order", 64'(err_order), 64'(0));
    checkOutput("t5_restart_err_ts", 64'(err_ts), 64'(0));
    checkOutput("t5_restart_err_count", 64'(err_count), 64'(0));
    applyStimulus(1'b0, 32'd0, 4'h0, 32'd0, 32'h0, 1'b1, 1'b1, 1'b0, "t5_end");
    waitDone(1'b0, "t5_done");

    $display("[TB] scenario 6: 4-bit timebase saturation edge");
    startRun(1'b1);
    applyStimulus(1'b1, 32'd0, 4'h8, 32'd1, 32'h0001, 1'b0, 1'b0, 1'b0, "t6_late");
    applyStimulus(1'b1, 32'd15, 4'hF, 32'd15, 32'h000F, 1'b0, 1'b1, 1'b1, "t6_e0");
    waitStrobe(1'b1, "t6_strobe_seen");
    tick();
    checkOutput("t6_done", 64'(done4), 64'(1));
    checkOutput("t6_now", 64'(now4), 64'(15));
    checkOutput("t6_err_count", 64'(err_count4), 64'(1));
    checkOutput("t6_err_order", 64'(err_order4), 64'(1));
    checkOutput("t6_err_ovf", 64'(err_ovf4), 64'(0));

    startRun(1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'd0, 4'h1, 32'd0, 32'h0, 1'b0, (i == 3), 1'b0, "t6_sat");
    waitDone(1'b1, "t6_sat_done");
    checkOutput("t6_err_count_sat", 64'(err_count4), 64'(3));

    $display("[TB] mid-run reset");
    startRun(1'b0);
    applyStimulus(1'b0, 32'd100, 4'h4, 32'd100, 32'h0100, 1'b0, 1'b1, 1'b0, "t7_e0");
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checkOutput("t7_busy", 64'(busy), 64'(0));
    checkOutput("t7_ready", 64'(in_ready), 64'(0));
    checkOutput("t7_now", 64'(now), 64'(0));
    checkOutput("t7_out_bin", 64'(out_bin), 64'(0));
    checkOutput("t7_out_hex", 64'(out_hex), 64'(0));
    checkOutput("t7_done4", 64'(done4), 64'(0));
    checkOutput("t7_err_count4", 64'(err_count4), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    checkOutput("queue_empty", 64'(q.size()), 64'(0));
    checkOutput("queue4_empty", 64'(q4.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
